axis_frame_fifo_writer: RTL
===========================

// Module: axis_frame_fifo_writer
// PURPOSE
//  AXI4-Stream slave that captures exactly FRAME_LEN beats per frame into a
//  FIFO write port (din/wr_en/full). It is the write-side counterpart of fifo_reader:
//  it buffers sample or FFT/CORDIC result frames for later readout.
//  It checks frame framing against s_axis_tlast and reports errors.
//  Capture is armed by a start pulse, or re-armed automatically (AUTO_REARM).
// PARAMETERS
//  FRAME_LEN   512  beats per frame (>=2)
//  DATA_WIDTH  14   tdata / FIFO din width
//  CNT_WIDTH   10   width of beat counter; 2^CNT_WIDTH > FRAME_LEN
//  AUTO_REARM  0    1: return to CAPTURE after DONE without needing start
// PORTS
//  clk               in   1           clock
//  rst               in   1           reset, synchronous, active-high
//  start             in   1           arm one frame capture (sampled in IDLE only)
//  s_axis_tdata      in   DATA_WIDTH  stream data
//  s_axis_tvalid     in   1           stream valid
//  s_axis_tlast      in   1           stream end-of-frame marker
//  s_axis_tready     out  1           stream ready
//  din               out  DATA_WIDTH  FIFO write data
//  wr_en             out  1           FIFO write enable
//  full              in   1           FIFO full flag
//  busy              out  1           high in CAPTURE and DONE
//  frame_done        out  1           1-cycle pulse after the last beat of a frame
//  err_tlast_early   out  1           sticky: tlast seen before beat FRAME_LEN-1
//  err_tlast_missing out  1           sticky: beat FRAME_LEN-1 accepted without tlast
//  word_cnt          out  CNT_WIDTH   beats accepted in the current frame
// BEHAVIOUR
//  Reset: state=IDLE. word_cnt, frame_done, busy, both err flags = 0.
//    s_axis_tready=0 and wr_en=0 from the first cycle with rst high.
//  accept = s_axis_tvalid & s_axis_tready.
//  s_axis_tready = (state==CAPTURE) & ~full. This is combinational from the registered state and the full input.
//  wr_en = accept; din = s_axis_tdata. Both are combinational, so there is zero latency.
//    The FIFO therefore never overflows, because each write is qualified by the current full.
//  State machine:
//   IDLE: start=1 -> CAPTURE, clears word_cnt and both err flags.
//     start=0 -> stay in IDLE. Beats are not accepted in IDLE.
//   CAPTURE: on accept with word_cnt<FRAME_LEN-1:
//     word_cnt++.
//     If tlast=1, set err_tlast_early. The capture continues; the frame is not truncated.
//   CAPTURE: on accept with word_cnt==FRAME_LEN-1:
//     if tlast=0, set err_tlast_missing.
//     word_cnt <= 0; -> DONE.
//   CAPTURE: no accept (tvalid=0 or full=1) -> hold all state.
//   DONE (1 cycle): frame_done=1, tready=0.
//     AUTO_REARM=0 -> IDLE. AUTO_REARM=1 -> CAPTURE, with err flags kept.
//  frame_done is registered. It is high exactly in the cycle after the final accept.
//  start is ignored outside IDLE; no re-trigger mid-frame.
//  Error flags are sticky until the next start is taken in IDLE, or until rst.
//  busy = (state!=IDLE).
//  rst mid-frame: the partial frame is abandoned and word_cnt returns to 0.
//    The FIFO has its own srst; the block does not flush it.
//  Back-to-back: with tvalid held high and full=0, FRAME_LEN beats take FRAME_LEN consecutive cycles.
// TESTING  (FRAME_LEN=8, DATA_WIDTH=14, AUTO_REARM=0 unless noted)
//  1 Reset, then start pulse; 8 beats 0x0001..0x0008 back-to-back with tlast on beat 8
//    -> 8 wr_en cycles, din=1..8 in order.
//    frame_done pulses the cycle after beat 8; no errors; IDLE; tready=0.
//  2 full=1 for cycles 3-5 of the frame -> tready=0 and no wr_en while full.
//    No beat is lost or duplicated; FIFO holds 1..8 exactly.
//  3 tlast on beat 4 and beat 8 -> err_tlast_early=1 and all 8 beats are written.
//    Beats after frame end are held off (tready=0).
//    Drive no tlast on beat 8 -> err_tlast_missing=1. A new start clears both flags.
//  4 Assert rst after 5 beats -> next cycle tready=0, word_cnt=0, busy=0.
//    Restart -> a full 8-beat frame completes normally.
//  5 AUTO_REARM=1: 24 continuous beats with tlast every 8th
//    -> 3 frame_done pulses, 24 writes (one bubble cycle per DONE), no errors.
//  6 start while busy, and tvalid high in IDLE -> both ignored; no wr_en in IDLE.

Source files
------------

// File: rtl/axis_frame_fifo_writer.sv
// rtl/axis_frame_fifo_writer.sv - AXI4-Stream slave capturing fixed-length frames into a FIFO write port
// Checks tlast framing against FRAME_LEN and flags early/missing tlast.
module axis_frame_fifo_writer #(
    parameter int FRAME_LEN  = 512,
    parameter int DATA_WIDTH = 14,
    parameter int CNT_WIDTH  = 10,
    parameter bit AUTO_REARM = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  wr_en,
    input  logic                  full,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_tlast_early,
    output logic                  err_tlast_missing,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(FRAME_LEN - 1);

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_word_cnt;
    logic                  r_err_early;
    logic                  r_err_missing;
    logic                  r_frame_done;

    state_t                w_state_nxt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic                  w_early_nxt;
    logic                  w_missing_nxt;
    logic                  w_done_nxt;
    logic                  w_ready;
    logic                  w_accept;

    // rst gates tready so no beat is taken while the state register is still being cleared
    assign w_ready  = (r_state == ST_CAPTURE) & ~full & ~rst;
    assign w_accept = s_axis_tvalid & w_ready;

    assign s_axis_tready     = w_ready;
    assign wr_en             = w_accept;
    assign din               = s_axis_tdata;
    assign busy              = (r_state != ST_IDLE);
    assign frame_done        = r_frame_done;
    assign err_tlast_early   = r_err_early;
    assign err_tlast_missing = r_err_missing;
    assign word_cnt          = r_word_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_word_cnt    <= '0;
            r_err_early   <= 1'b0;
            r_err_missing <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_word_cnt    <= w_cnt_nxt;
            r_err_early   <= w_early_nxt;
            r_err_missing <= w_missing_nxt;
            r_frame_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_word_cnt;
        w_early_nxt   = r_err_early;
        w_missing_nxt = r_err_missing;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt   = ST_CAPTURE;
                    w_cnt_nxt     = '0;
                    w_early_nxt   = 1'b0;
                    w_missing_nxt = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (w_accept) begin
                    if (r_word_cnt == LP_LAST) begin
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                        if (!s_axis_tlast) w_missing_nxt = 1'b1;
                    end else begin
                        // an early tlast is only recorded; the frame still runs to FRAME_LEN beats
                        w_cnt_nxt = r_word_cnt + CNT_WIDTH'(1);
                        if (s_axis_tlast) w_early_nxt = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = AUTO_REARM ? ST_CAPTURE : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
